// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: data width, NOP encoding, fetch state and response struct.
package pipeline_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MAX_FETCH_WIDTH = 4;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    IMEM_INIT,
    IMEM_RUN
  } imem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]                       pc;
    logic                                  fault;
    logic [MAX_FETCH_WIDTH-1:0][XLEN-1:0]  inst;
  } fetch_resp_t;

endpackage

// File: rtl/imem_word_array.sv
// Word-addressed instruction storage: one write port, FETCH_WIDTH consecutive combinational reads.
module imem_word_array
  import pipeline_pkg::*;
#(
  parameter int unsigned WORD_AW     = 8,
  parameter int unsigned FETCH_WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [WORD_AW-1:0]          waddr_i,
  input  logic [XLEN-1:0]             wdata_i,
  input  logic [WORD_AW-1:0]          raddr_i,
  output logic [XLEN*FETCH_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << WORD_AW;

  logic [XLEN-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Lane index wraps here; the fetch unit flags any request that would need the wrap.
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    assign rdata_o[XLEN*g +: XLEN] = mem_q[raddr_i + WORD_AW'(g)];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with registered, handshaked multi-lane fetch port and word load port.
// Define IMEM_INIT_CLEAR_EN to enable the post-reset sweep that zeroes the whole array.
module imem_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH  = 10,
  parameter int unsigned     FETCH_WIDTH = 1,
  parameter logic [XLEN-1:0] NOP_INST    = NOP_INST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [XLEN-1:0]             req_pc,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [XLEN-1:0]             resp_pc,
  output logic [XLEN*FETCH_WIDTH-1:0] resp_inst,
  output logic                        resp_fault,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  output logic                        init_done
);

  localparam int unsigned WordAw = ADDR_WIDTH - 2;

  logic                        run;
  logic                        mem_we;
  logic [WordAw-1:0]           mem_waddr;
  logic [XLEN-1:0]             mem_wdata;
  logic [XLEN*FETCH_WIDTH-1:0] rd_data;

`ifdef IMEM_INIT_CLEAR_EN
  imem_state_e       state_q;
  logic [WordAw-1:0] clr_ptr_q;
  logic              init_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IMEM_INIT;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IMEM_INIT: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (&clr_ptr_q) begin
            state_q     <= IMEM_RUN;
            init_done_q <= 1'b1;
          end
        end
        IMEM_RUN: begin
        end
      endcase
    end
  end

  assign run       = init_done_q;
  assign init_done = init_done_q;
  // The sweep owns the write port; load-port writes are dropped until it finishes.
  assign mem_we    = (state_q == IMEM_INIT) ? 1'b1      : wr_en;
  assign mem_waddr = (state_q == IMEM_INIT) ? clr_ptr_q : wr_addr[ADDR_WIDTH-1:2];
  assign mem_wdata = (state_q == IMEM_INIT) ? '0        : wr_data;
`else
  assign run       = 1'b1;
  assign init_done = 1'b1;
  assign mem_we    = wr_en;
  assign mem_waddr = wr_addr[ADDR_WIDTH-1:2];
  assign mem_wdata = wr_data;
`endif

  logic unused_wr_lsb;
  assign unused_wr_lsb = ^wr_addr[1:0];

  logic [WordAw-1:0] word_idx;
  logic [WordAw:0]   last_idx;
  logic              fault;

  assign word_idx = req_pc[ADDR_WIDTH-1:2];
  // A carry out of the last-lane index means the fetch runs past the top of the array.
  assign last_idx = {1'b0, word_idx} + (WordAw + 1)'(FETCH_WIDTH - 1);
  assign fault    = (|req_pc[1:0]) | (|req_pc[XLEN-1:ADDR_WIDTH]) | last_idx[WordAw];

  imem_word_array #(
    .WORD_AW    (WordAw),
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(word_idx),
    .rdata_o(rd_data)
  );

  fetch_resp_t resp_q, resp_d;
  logic        resp_valid_q, resp_valid_d;
  logic        accept;

  assign req_ready = run && !flush && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (accept) begin
      resp_valid_d = 1'b1;
      resp_d.pc    = req_pc;
      resp_d.fault = fault;
      resp_d.inst  = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        resp_d.inst[i] = fault ? NOP_INST : rd_data[XLEN*i +: XLEN];
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  if (FETCH_WIDTH < MAX_FETCH_WIDTH) begin : g_unused_lanes
    logic unused_lanes;
    assign unused_lanes = ^resp_q.inst[MAX_FETCH_WIDTH-1:FETCH_WIDTH];
  end

  assign resp_valid = resp_valid_q;
  assign resp_pc    = resp_q.pc;
  assign resp_fault = resp_q.fault;
  assign resp_inst  = resp_q.inst[FETCH_WIDTH-1:0];

endmodule
